// File: rtl/univ_shift_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usr_pkg
//  Description : Shared constants for the universal shift register.
//                Defines the 3-bit operation encodings on the mode bus.
//  Optional    : UNIV_SHIFT_PARITY_EN (used by the interface and top only)
//  Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
  // 3'b110 and 3'b111 are reserved and act as HOLD.

endpackage : usr_pkg
`default_nettype wire

// File: rtl/univ_shift_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : univ_shift_reg_if
//  Description : Control/data bundle of the universal shift register.
//                master : drives en, mode, s_in_r, s_in_l, d; observes outputs
//                slave  : the register itself; drives q, s_out_r, s_out_l,
//                         cnt, done (and parity when enabled)
//  Optional    : UNIV_SHIFT_PARITY_EN adds the 1-bit parity signal
//  Revision    : 1.0 - initial release
// ============================================================================
interface univ_shift_reg_if
  import usr_pkg::*;
#(
  parameter int N = 8
);

  localparam int CW = $clog2(N + 1);

  logic              en;
  logic [MODE_W-1:0] mode;
  logic              s_in_r;
  logic              s_in_l;
  logic [N-1:0]      d;
  logic [N-1:0]      q;
  logic              s_out_r;
  logic              s_out_l;
  logic [CW-1:0]     cnt;
  logic              done;
`ifdef UNIV_SHIFT_PARITY_EN
  logic              parity;
`endif

  modport master (
    output en, mode, s_in_r, s_in_l, d,
`ifdef UNIV_SHIFT_PARITY_EN
    input  parity,
`endif
    input  q, s_out_r, s_out_l, cnt, done
  );

  modport slave (
    input  en, mode, s_in_r, s_in_l, d,
`ifdef UNIV_SHIFT_PARITY_EN
    output parity,
`endif
    output q, s_out_r, s_out_l, cnt, done
  );

endinterface : univ_shift_reg_if
`default_nettype wire

// File: rtl/univ_shift_reg_shift_frame_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : shift_frame_cnt
//  Description : Saturating count of serial operations in the current frame
//                plus a one-cycle frame-complete pulse.
//  Ports       : clk   - rising-edge clock
//                reset - synchronous active-low reset
//                clr   - restart the frame (parallel load)
//                inc   - one shift/rotate performed this cycle
//                cnt   - operations since last clear, saturates at N
//                done  - registered pulse on the N-1 -> N transition
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_frame_cnt #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d  = cnt_q + CW'(1);
      // Only the step that reaches N fires; saturated shifts never re-fire.
      done_d = (cnt_q == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule : shift_frame_cnt
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : univ_shift_reg
//  Description : Parametrised universal shift register: hold, shift right/left,
//                rotate right/left and parallel load, with a saturating frame
//                counter and frame-complete pulse.
//  Ports       : clk   - rising-edge clock
//                reset - synchronous active-low reset
//                bus   - univ_shift_reg_if.slave (en, mode, s_in_r, s_in_l, d
//                        in; q, s_out_r, s_out_l, cnt, done out)
//  Optional    : UNIV_SHIFT_PARITY_EN adds registered even-parity of q
//  Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              reset,
  univ_shift_reg_if.slave   bus
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0] q_q, q_d;
  logic         is_load;
  logic         is_shift;

  // en=0 forces hold and keeps the counter idle.
  always_comb begin
    q_d      = q_q;
    is_load  = 1'b0;
    is_shift = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        MODE_SHR: begin
          q_d      = {bus.s_in_r, q_q[N-1:1]};
          is_shift = 1'b1;
        end
        MODE_SHL: begin
          q_d      = {q_q[N-2:0], bus.s_in_l};
          is_shift = 1'b1;
        end
        MODE_LOAD: begin
          q_d     = bus.d;
          is_load = 1'b1;
        end
        MODE_ROR: begin
          q_d      = {q_q[0], q_q[N-1:1]};
          is_shift = 1'b1;
        end
        MODE_ROL: begin
          q_d      = {q_q[N-2:0], q_q[N-1]};
          is_shift = 1'b1;
        end
        default: q_d = q_q;  // HOLD and reserved encodings
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  shift_frame_cnt #(
    .N  (N),
    .CW (CW)
  ) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (is_load),
    .inc   (is_shift),
    .cnt   (bus.cnt),
    .done  (bus.done)
  );

`ifdef UNIV_SHIFT_PARITY_EN
  logic parity_q;

  // Computed from the next value so parity lines up with q on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^q_d;
    end
  end

  assign bus.parity = parity_q;
`endif

  assign bus.q       = q_q;
  assign bus.s_out_r = q_q[0];
  assign bus.s_out_l = q_q[N-1];

endmodule : univ_shift_reg
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_univ_shift_reg
//  Description : Self-checking bench for univ_shift_reg (N=8). Directed
//                vectors push their hand-computed expected state into a
//                scoreboard queue; a monitor pops and compares after each edge.
//  Optional    : UNIV_SHIFT_PARITY_EN also compares the parity output
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;
  import usr_pkg::*;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  typedef struct {
    logic [N-1:0]  q;
    logic [CW-1:0] cnt;
    logic          done;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   passed;
  exp_t sb[$];

  univ_shift_reg_if #(.N(N)) bus ();

  univ_shift_reg #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one operation on the falling edge and queue its post-edge state.
  task automatic vec(input logic rst_n, input logic en, input logic [MODE_W-1:0] mode,
                     input logic sr, input logic sl, input logic [N-1:0] d,
                     input logic [N-1:0] eq, input int ec, input logic ed);
    exp_t e;
    @(negedge clk);
    reset      = rst_n;
    bus.en     = en;
    bus.mode   = mode;
    bus.s_in_r = sr;
    bus.s_in_l = sl;
    bus.d      = d;
    e.q    = eq;
    e.cnt  = CW'(ec);
    e.done = ed;
    sb.push_back(e);
  endtask

  // Monitor: every edge that follows a queued operation is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q",       32'(bus.q),       32'(e.q));
        chk("cnt",     32'(bus.cnt),     32'(e.cnt));
        chk("done",    32'(bus.done),    32'(e.done));
        chk("s_out_r", 32'(bus.s_out_r), 32'(e.q[0]));
        chk("s_out_l", 32'(bus.s_out_l), 32'(e.q[N-1]));
`ifdef UNIV_SHIFT_PARITY_EN
        chk("parity",  32'(bus.parity),  32'(^e.q));
`endif
      end
    end
  end

  initial begin
    logic [7:0] shr_seq [8];
    logic [7:0] ror_seq [8];
    int wait_cyc;
    total = 0;
    passed = 0;
    reset = 1'b0;
    bus.en = 1'b0;
    bus.mode = MODE_HOLD;
    bus.s_in_r = 1'b0;
    bus.s_in_l = 1'b0;
    bus.d = '0;
    shr_seq = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    ror_seq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    // Reset dominates a pending LOAD
    vec(0, 1, MODE_LOAD, 0, 0, 8'hFF, 8'h00, 0, 0);
    vec(0, 1, MODE_LOAD, 0, 0, 8'hFF, 8'h00, 0, 0);
    vec(1, 1, MODE_LOAD, 0, 0, 8'hFF, 8'hFF, 0, 0);

    // SHR frame with s_in_r=1, then one saturated shift
    vec(1, 1, MODE_LOAD, 0, 0, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++)
      vec(1, 1, MODE_SHR, 1, 0, 8'h00, shr_seq[i], i + 1, (i == 7));
    vec(1, 1, MODE_SHR, 1, 0, 8'h00, 8'hFF, 8, 0);

    // ROL then SHL
    vec(1, 1, MODE_LOAD, 0, 0, 8'h81, 8'h81, 0, 0);
    vec(1, 1, MODE_ROL,  0, 0, 8'h00, 8'h03, 1, 0);
    vec(1, 1, MODE_SHL,  0, 0, 8'h00, 8'h06, 2, 0);
    vec(1, 1, MODE_SHL,  0, 1, 8'h00, 8'h0D, 3, 0);

    // ROR wraps back after N steps, single done pulse
    vec(1, 1, MODE_LOAD, 0, 0, 8'h01, 8'h01, 0, 0);
    for (int i = 0; i < 8; i++)
      vec(1, 1, MODE_ROR, 0, 0, 8'h00, ror_seq[i], i + 1, (i == 7));
    vec(1, 1, MODE_ROR, 0, 0, 8'h00, 8'h80, 8, 0);

    // en=0 and reserved modes hold
    vec(1, 1, MODE_LOAD, 0, 0, 8'hA5, 8'hA5, 0, 0);
    for (int i = 0; i < 3; i++)
      vec(1, 0, MODE_SHR, 1, 1, 8'h00, 8'hA5, 0, 0);
    vec(1, 1, 3'b111, 1, 1, 8'h00, 8'hA5, 0, 0);
    vec(1, 1, 3'b110, 1, 1, 8'h00, 8'hA5, 0, 0);
    vec(1, 1, MODE_HOLD, 1, 1, 8'h00, 8'hA5, 0, 0);

    // Reset mid-frame discards the partial frame
    vec(1, 1, MODE_LOAD, 0, 0, 8'h3C, 8'h3C, 0, 0);
    vec(1, 1, MODE_SHR, 0, 0, 8'h00, 8'h1E, 1, 0);
    vec(1, 1, MODE_SHR, 0, 0, 8'h00, 8'h0F, 2, 0);
    vec(1, 1, MODE_SHR, 0, 0, 8'h00, 8'h07, 3, 0);
    vec(1, 1, MODE_SHR, 0, 0, 8'h00, 8'h03, 4, 0);
    vec(1, 1, MODE_SHR, 0, 0, 8'h00, 8'h01, 5, 0);
    vec(0, 1, MODE_SHR, 1, 0, 8'h00, 8'h00, 0, 0);
    vec(1, 1, MODE_SHR, 1, 0, 8'h00, 8'h80, 1, 0);
    vec(1, 1, MODE_SHR, 1, 0, 8'h00, 8'hC0, 2, 0);
    vec(1, 1, MODE_SHR, 1, 0, 8'h00, 8'hE0, 3, 0);

    // Parity patterns (odd and even weight)
    vec(1, 1, MODE_LOAD, 0, 0, 8'h07, 8'h07, 0, 0);
    vec(1, 1, MODE_LOAD, 0, 0, 8'h03, 8'h03, 0, 0);
    vec(1, 0, MODE_HOLD, 0, 0, 8'h00, 8'h03, 0, 0);

    // Drain the scoreboard with a bounded wait
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #3;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_univ_shift_reg
`default_nettype wire
